zeroriscy_instr_mem_responder: RTL and testbench
================================================

# zeroriscy_instr_mem_responder

Memory-side responder for the core's instruction fetch protocol (instr_req/instr_gnt/instr_addr/instr_rdata/instr_rvalid). It sits between the prefetch buffer and a single-port synchronous instruction SRAM, and answers fetch requests with configurable grant stall and rvalid latency. It is used as the instruction memory in the core testbench and in small FPGA builds, and exercises the prefetch buffer's WAIT_GNT, WAIT_RVALID and WAIT_ABORTED paths.

## Interface
Parameters:
- ADDR_WIDTH, 12: SRAM word-address width; memory holds 2^ADDR_WIDTH 32-bit words.
- GNT_STALL, 0: cycles instr_req_i must be held before instr_gnt_o is asserted. Range 0..15.
- RVALID_LAT, 1: cycles from the grant cycle to the instr_rvalid_o cycle. Range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- instr_req_i  in  1  fetch request from initiator
- instr_gnt_o  out  1  request accepted this cycle
- instr_addr_i  in  32  byte address; bits [1:0] ignored
- instr_rdata_o  out  32  read data, valid with instr_rvalid_o
- instr_rvalid_o  out  1  one-cycle response strobe
- mem_req_o  out  1  SRAM read enable
- mem_addr_o  out  ADDR_WIDTH  SRAM word address = instr_addr_i[ADDR_WIDTH+1:2]
- mem_rdata_i  in  32  SRAM data, one cycle after mem_req_o
- busy_o  out  1  state != IDLE or instr_req_i

## Operation
- States: IDLE, WAIT_STALL (counting grant stall), WAIT_DATA (one response outstanding).
- At most one outstanding response. A new grant is allowed only when nothing is outstanding, or in the cycle instr_rvalid_o=1 for the previous request.
- Grant condition (grant_ok): instr_req_i=1, stall counter reached GNT_STALL, and the slot is free. In a grant cycle: instr_gnt_o=1, mem_req_o=1, mem_addr_o driven from the current instr_addr_i. The address is sampled only in the grant cycle, so changes during the stall (branch redirect) are honoured.
- IDLE: if req=1 and GNT_STALL=0, grant and go to WAIT_DATA. If req=1 and GNT_STALL>0, go to WAIT_STALL with stall_cnt=1.
- WAIT_STALL: stall_cnt increments while req=1. When stall_cnt=GNT_STALL, grant and go to WAIT_DATA. If req=0, go to IDLE and clear stall_cnt.
- WAIT_DATA: lat_cnt counts from 1 in the cycle after the grant. At lat_cnt=RVALID_LAT, assert instr_rvalid_o. In that same cycle:
  - if grant_ok with GNT_STALL=0: grant, stay in WAIT_DATA, restart lat_cnt;
  - else if req=1: go to WAIT_STALL;
  - else go to IDLE.
- Data path:
  - RVALID_LAT=1: instr_rdata_o = mem_rdata_i passed through.
  - RVALID_LAT>1: mem_rdata_i is captured into rdata_q on the edge ending grant+1; instr_rdata_o = rdata_q.
- instr_rdata_o is don't-care when instr_rvalid_o=0; it is held at its last value.
- Address wraps: upper bits above ADDR_WIDTH+1 are ignored.

## Timing
- Reset values: instr_gnt_o=0, instr_rvalid_o=0, instr_rdata_o=0, mem_req_o=0, mem_addr_o=0, busy_o=0. State=IDLE, counters=0.
- Grant is combinational from instr_req_i in the grant-eligible cycle. rvalid is registered.
- Grant cycle T, then rvalid at T+RVALID_LAT.
- Minimum request-to-grant: GNT_STALL cycles after first req.
- Throughput: 1 word/cycle with GNT_STALL=0 and RVALID_LAT=1. Otherwise one word per max(RVALID_LAT, GNT_STALL+RVALID_LAT) cycles.
- Reset mid-operation drops any outstanding response; no rvalid is produced after reset release.
- Initiator abort (WAIT_ABORTED) is not visible to the responder. Every grant produces exactly one rvalid.

## Configuration
- ZERORISCY_RESP_RANDOM_STALL_EN defined:
  - a 16-bit LFSR (seed 16'hACE1, taps 16,14,13,11) advances every cycle;
  - grant_ok additionally requires lfsr[0]=0, adding pseudo-random grant stalls on top of GNT_STALL;
  - the stall counter saturates at GNT_STALL.
- Undefined: no LFSR; grant timing is exactly GNT_STALL.

## Structure
- Package zeroriscy_resp_pkg: state enum resp_state_e (IDLE, WAIT_STALL, WAIT_DATA), LFSR_SEED, LFSR width constant.
- Sub-module zeroriscy_resp_lfsr (enable, state out). Instantiated only under ZERORISCY_RESP_RANDOM_STALL_EN.

## Test plan
- GNT_STALL=0, RVALID_LAT=1, req held with addr 0x0,0x4,0x8 -> gnt every cycle, rvalid at T+1,T+2,T+3 with mem words 0,1,2.
- GNT_STALL=2, req at cycle 0 with addr 0x10 -> gnt at cycle 2, mem_addr_o=4, rvalid at cycle 3.
- GNT_STALL=3, addr changes 0x20->0x80 at cycle 1 -> grant at cycle 3 uses word 0x20, data of word 32 returned.
- RVALID_LAT=3, req continuously -> grants at T and T+3, rvalid at T+3 coincides with second grant, data correct.
- Reset asserted one cycle after grant with RVALID_LAT=4 -> all outputs 0, no rvalid after release.
- With ZERORISCY_RESP_RANDOM_STALL_EN, 1000 random fetches -> every grant gets exactly one rvalid, data matches model, no deadlock.

Source files
------------

// File: rtl/zeroriscy_resp_pkg.sv
// rtl/zeroriscy_resp_pkg.sv - shared state type and constants for the instruction memory responder
package zeroriscy_resp_pkg;

  typedef enum logic [1:0] {
    IDLE,
    WAIT_STALL,
    WAIT_DATA
  } resp_state_e;

  localparam int LFSR_WIDTH = 16;
  localparam logic [LFSR_WIDTH-1:0] LFSR_SEED = 16'hACE1;

  // Wide enough for GNT_STALL and RVALID_LAT up to 15
  localparam int CNT_WIDTH = 4;

endpackage

// File: rtl/zeroriscy_resp_lfsr.sv
// rtl/zeroriscy_resp_lfsr.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11) driving random grant stalls
module zeroriscy_resp_lfsr
  import zeroriscy_resp_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  output logic [LFSR_WIDTH-1:0] state_o
);

  logic [LFSR_WIDTH-1:0] lfsr_q, lfsr_d;
  logic                  feedback;

  always_comb begin
    feedback = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];
    lfsr_d   = lfsr_q;
    if (en_i) begin
      lfsr_d = {lfsr_q[LFSR_WIDTH-2:0], feedback};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lfsr_q <= LFSR_SEED;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign state_o = lfsr_q;

endmodule

// File: rtl/zeroriscy_instr_mem_responder.sv
// rtl/zeroriscy_instr_mem_responder.sv - fetch-protocol responder over a synchronous SRAM; ZERORISCY_RESP_RANDOM_STALL_EN adds LFSR grant stalls
module zeroriscy_instr_mem_responder
  import zeroriscy_resp_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int GNT_STALL  = 0,
  parameter int RVALID_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  instr_req_i,
  output logic                  instr_gnt_o,
  input  logic [31:0]           instr_addr_i,
  output logic [31:0]           instr_rdata_o,
  output logic                  instr_rvalid_o,
  output logic                  mem_req_o,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o
);

  localparam logic [CNT_WIDTH-1:0] STALL_MAX  = CNT_WIDTH'(GNT_STALL);
  localparam logic [CNT_WIDTH-1:0] LAT_MAX    = CNT_WIDTH'(RVALID_LAT);
  localparam logic [CNT_WIDTH-1:0] STALL_INIT = (GNT_STALL > 0) ? CNT_WIDTH'(1) : '0;

  resp_state_e          state_q, state_d;
  logic [CNT_WIDTH-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_WIDTH-1:0] lat_cnt_q, lat_cnt_d;
  logic [31:0]          rdata_q, rdata_d;
  logic                 rvalid, slot_free, stall_done, random_ok, grant_ok;

`ifdef ZERORISCY_RESP_RANDOM_STALL_EN
  logic [LFSR_WIDTH-1:0] lfsr;
  logic                  unused_lfsr;

  zeroriscy_resp_lfsr u_lfsr (
    .clk     (clk),
    .rst_n   (rst_n),
    .en_i    (1'b1),
    .state_o (lfsr)
  );

  assign random_ok   = ~lfsr[0];
  assign unused_lfsr = ^lfsr[LFSR_WIDTH-1:1];
`else
  assign random_ok = 1'b1;
`endif

  assign rvalid     = (state_q == WAIT_DATA) && (lat_cnt_q == LAT_MAX);
  // The slot frees up in the rvalid cycle itself so back-to-back fetches are possible
  assign slot_free  = (state_q != WAIT_DATA) || rvalid;
  assign stall_done = (GNT_STALL == 0) ||
                      ((state_q == WAIT_STALL) && (stall_cnt_q == STALL_MAX));
  assign grant_ok   = instr_req_i && stall_done && slot_free && random_ok;

  always_comb begin
    state_d     = state_q;
    stall_cnt_d = stall_cnt_q;
    lat_cnt_d   = lat_cnt_q;
    if (grant_ok) begin
      state_d     = WAIT_DATA;
      stall_cnt_d = '0;
      lat_cnt_d   = CNT_WIDTH'(1);
    end else begin
      unique case (state_q)
        IDLE: begin
          if (instr_req_i) begin
            state_d     = WAIT_STALL;
            stall_cnt_d = STALL_INIT;
          end
        end
        WAIT_STALL: begin
          if (!instr_req_i) begin
            state_d     = IDLE;
            stall_cnt_d = '0;
          end else if (stall_cnt_q != STALL_MAX) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
          end
        end
        WAIT_DATA: begin
          if (rvalid) begin
            lat_cnt_d = '0;
            if (instr_req_i) begin
              state_d     = WAIT_STALL;
              stall_cnt_d = STALL_INIT;
            end else begin
              state_d = IDLE;
            end
          end else begin
            lat_cnt_d = lat_cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  generate
    if (RVALID_LAT == 1) begin : g_bypass
      always_comb begin
        rdata_d = rdata_q;
        if (rvalid) begin
          rdata_d = mem_rdata_i;
        end
      end
      assign instr_rdata_o = rvalid ? mem_rdata_i : rdata_q;
    end else begin : g_capture
      // SRAM data is only valid in the cycle after the grant, so capture it there
      always_comb begin
        rdata_d = rdata_q;
        if ((state_q == WAIT_DATA) && (lat_cnt_q == CNT_WIDTH'(1))) begin
          rdata_d = mem_rdata_i;
        end
      end
      assign instr_rdata_o = rdata_q;
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      stall_cnt_q <= '0;
      lat_cnt_q   <= '0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      lat_cnt_q   <= lat_cnt_d;
      rdata_q     <= rdata_d;
    end
  end

  logic unused_addr;
  assign unused_addr = ^{instr_addr_i[31:ADDR_WIDTH+2], instr_addr_i[1:0]};

  assign instr_gnt_o    = grant_ok;
  assign mem_req_o      = grant_ok;
  assign mem_addr_o     = grant_ok ? instr_addr_i[ADDR_WIDTH+1:2] : '0;
  assign instr_rvalid_o = rvalid;
  assign busy_o         = (state_q != IDLE) || instr_req_i;

endmodule

// File: tb/tb_zeroriscy_instr_mem_responder.sv
// tb/tb_zeroriscy_instr_mem_responder.sv - scoreboard bench over four stall/latency configurations
module tb_zeroriscy_instr_mem_responder;

  localparam int NCFG = 4;
  localparam int AW   = 12;

  function automatic int cfg_g(int i);
    case (i)
      0:       return 0;
      1:       return 2;
      2:       return 0;
      default: return 3;
    endcase
  endfunction

  function automatic int cfg_l(int i);
    case (i)
      0:       return 1;
      1:       return 1;
      2:       return 3;
      default: return 4;
    endcase
  endfunction

  function automatic logic [31:0] mem_word(logic [AW-1:0] w);
    return {w, 4'h5, ~w, 4'hA};
  endfunction

  typedef struct {
    int unsigned due;
    logic [31:0] data;
  } resp_t;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NCFG-1:0] req, gnt, rvalid, mem_req, busy;
  logic [31:0]     addr     [NCFG];
  logic [31:0]     rdata    [NCFG];
  logic [AW-1:0]   mem_addr [NCFG];

  always #5 clk = ~clk;

  for (genvar g = 0; g < NCFG; g++) begin : g_dut
    logic [31:0] sram_rdata;

    always @(posedge clk) begin
      if (mem_req[g]) sram_rdata <= mem_word(mem_addr[g]);
    end

    zeroriscy_instr_mem_responder #(
      .ADDR_WIDTH (AW),
      .GNT_STALL  (cfg_g(g)),
      .RVALID_LAT (cfg_l(g))
    ) u_dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .instr_req_i    (req[g]),
      .instr_gnt_o    (gnt[g]),
      .instr_addr_i   (addr[g]),
      .instr_rdata_o  (rdata[g]),
      .instr_rvalid_o (rvalid[g]),
      .mem_req_o      (mem_req[g]),
      .mem_addr_o     (mem_addr[g]),
      .mem_rdata_i    (sram_rdata),
      .busy_o         (busy[g])
    );
  end

  resp_t       exp_q [NCFG][$];
  int          run        [NCFG];
  bit          stall_prev [NCFG];
  int unsigned cyc;
  int          checks;
  int          failures;

  task automatic chk(string name, int g, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cfg%0d cyc=%0d actual=%h expected=%h", name, g, cyc, act, exp);
    end
  endtask

  // Reference: a grant needs GNT_STALL+1 consecutive requesting cycles while the slot
  // is free (no response pending, or the pending one returns this cycle); each grant
  // returns mem_word(addr) exactly RVALID_LAT cycles later.
  initial begin
    cyc      = 0;
    checks   = 0;
    failures = 0;
    for (int g = 0; g < NCFG; g++) begin
      run[g]        = 0;
      stall_prev[g] = 1'b0;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int g = 0; g < NCFG; g++) begin
        if (!rst_n) begin
          chk("reset_outputs", g,
              {26'd0, gnt[g], rvalid[g], mem_req[g], busy[g], |mem_addr[g], |rdata[g]}, 32'd0);
          exp_q[g].delete();
          run[g]        = 0;
          stall_prev[g] = 1'b0;
        end else begin
          bit outstanding;
          bit due_now;
          bit free;
          bit exp_gnt;
          outstanding = exp_q[g].size() != 0;
          due_now     = outstanding && (exp_q[g][0].due == cyc);
          free        = !outstanding || due_now;
          chk("busy", g, 32'(busy[g]), 32'(req[g] || outstanding || stall_prev[g]));
          chk("rvalid", g, 32'(rvalid[g]), 32'(due_now));
          if (due_now) begin
            chk("rdata", g, rdata[g], exp_q[g][0].data);
            void'(exp_q[g].pop_front());
          end
          run[g]  = (req[g] && free) ? run[g] + 1 : 0;
          exp_gnt = req[g] && free && (run[g] >= cfg_g(g) + 1);
          chk("gnt", g, 32'(gnt[g]), 32'(exp_gnt));
          chk("mem_req", g, 32'(mem_req[g]), 32'(exp_gnt));
          if (exp_gnt) begin
            chk("mem_addr", g, 32'(mem_addr[g]), 32'(addr[g][AW+1:2]));
            exp_q[g].push_back('{due: cyc + cfg_l(g), data: mem_word(addr[g][AW+1:2])});
            run[g] = 0;
          end
          stall_prev[g] = req[g] && free && !exp_gnt;
        end
      end
    end
  end

  initial begin
    logic [NCFG-1:0] taken;
    rst_n = 1'b0;
    req   = '0;
    for (int g = 0; g < NCFG; g++) addr[g] = '0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Sequential fetch stream starting at 0x0 with req held
    req = '1;
    repeat (30) begin
      @(negedge clk);
      taken = req & gnt;
      @(posedge clk);
      #1;
      for (int g = 0; g < NCFG; g++) begin
        if (taken[g]) addr[g] = addr[g] + 32'd4;
      end
    end

    // Random fetches with redirects and abandoned requests during the stall
    repeat (1500) begin
      @(negedge clk);
      taken = req & gnt;
      @(posedge clk);
      #1;
      for (int g = 0; g < NCFG; g++) begin
        if (req[g] && !taken[g]) begin
          if ($urandom_range(0, 7) == 0) addr[g] = $urandom;
          if ($urandom_range(0, 15) == 0) req[g] = 1'b0;
        end else begin
          req[g]  = ($urandom_range(0, 3) != 0);
          addr[g] = $urandom;
        end
      end
    end

    // Reset one cycle after the GNT_STALL=3 / RVALID_LAT=4 grant
    req = '0;
    repeat (8) @(posedge clk);
    #1;
    for (int g = 0; g < NCFG; g++) addr[g] = $urandom;
    req = '1;
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    req   = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (12) @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
